// File: rtl/mcp_pkg.sv
// Shared types for the multicycle MIPS memory arbiter.
// Holds the arbiter FSM states and the requester id constants.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic CORE = 1'b0;
  localparam logic LDR  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, and a tie
// goes to whichever requester was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified MIPS memory between the core and the program loader,
// running each access as a fixed-latency transaction ending in a ready pulse.
module mem_arbiter
  import mcp_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ready,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] coreRdata_q, coreRdata_d;
  logic [DW-1:0] ldrRdata_q, ldrRdata_d;
  logic          gntValid;
  logic          gntId;

  rr_pick2 u_pick (
    .req       ({ldr_req, core_req}),
    .last      (last_q),
    .gnt_valid (gntValid),
    .gnt_id    (gntId)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gntValid) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registers, so an asynchronous reset
  // drops the memory strobes in the same instant.
  always_comb begin
    mem_en     = (state_q == ACCESS);
    mem_we     = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
    core_ready = (state_q == DONE) && (gnt_q == CORE);
    ldr_ready  = (state_q == DONE) && (gnt_q == LDR);
    busy       = (state_q != IDLE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    core_rdata = coreRdata_q;
    ldr_rdata  = ldrRdata_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    coreRdata_d = coreRdata_q;
    ldrRdata_d  = ldrRdata_q;
    unique case (state_q)
      IDLE: begin
        if (gntValid) begin
          gnt_d   = gntId;
          we_d    = (gntId == LDR) ? ldr_we    : core_we;
          addr_d  = (gntId == LDR) ? ldr_addr  : core_addr;
          wdata_d = (gntId == LDR) ? ldr_wdata : core_wdata;
          cnt_d   = CNT_INIT;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!we_q) begin
          if (gnt_q == LDR) ldrRdata_d  = mem_rdata;
          else              coreRdata_d = mem_rdata;
        end
      end
      DONE:    last_d = gnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      last_q      <= LDR;
      gnt_q       <= CORE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      coreRdata_q <= '0;
      ldrRdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      coreRdata_q <= coreRdata_d;
      ldrRdata_q  <= ldrRdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    bit          cReq;
    bit          lReq;
    bit          cWe;
    bit          lWe;
    logic [31:0] cAddr;
    logic [31:0] lAddr;
    logic [31:0] cData;
    logic [31:0] lData;
    bit          expWin;
    logic [31:0] expCoreRd;
    logic [31:0] expLdrRd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, ldr_req, ldr_we;
  logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic [31:0] core_rdata, ldr_rdata;
  logic        core_ready, ldr_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic        loadMem;

  logic [31:0] tbMem    [0:63];
  logic [31:0] modelMem [0:63];
  logic        modelLast;
  logic [31:0] modelCoreRd, modelLdrRd;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [9];

  mem_arbiter #(.AW(32), .DW(32), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_rdata  (ldr_rdata),
    .ldr_ready  (ldr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bench-side memory: combinational read, write committed on the clock edge.
  assign mem_rdata = tbMem[mem_addr[7:2]];

  always @(posedge clk or posedge loadMem) begin
    if (loadMem) begin
      for (int i = 0; i < 64; i++) tbMem[i] <= (i == 2) ? 32'h2002_0005 : 32'hA500_0000 + 32'(i);
    end else if (mem_we) begin
      tbMem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset    = 1'b0;
    core_req = 1'b0;
    ldr_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    modelLast   = 1'b1;
    modelCoreRd = '0;
    modelLdrRd  = '0;
  endtask

  // Runs one arbitrated transaction from IDLE and checks timing, strobes and data.
  task automatic applyStimulus(input vec_t v);
    int          enCnt, weCnt, weAt, readyAt, gotCore, gotLdr;
    bit          addrBad, dataBad, expWe;
    logic [31:0] expAddr, expData;
    core_req   = v.cReq;  ldr_req   = v.lReq;
    core_we    = v.cWe;   ldr_we    = v.lWe;
    core_addr  = v.cAddr; ldr_addr  = v.lAddr;
    core_wdata = v.cData; ldr_wdata = v.lData;
    expWe   = v.expWin ? v.lWe   : v.cWe;
    expAddr = v.expWin ? v.lAddr : v.cAddr;
    expData = v.expWin ? v.lData : v.cData;
    enCnt = 0; weCnt = 0; weAt = 0; readyAt = 0; gotCore = 0; gotLdr = 0;
    addrBad = 1'b0; dataBad = 1'b0;
    for (int cyc = 1; cyc <= LAT + 4 && readyAt == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_en) begin
        enCnt++;
        if (mem_addr !== expAddr) addrBad = 1'b1;
      end
      if (mem_we) begin
        weCnt++;
        weAt = cyc;
        if (mem_wdata !== expData || mem_addr !== expAddr) dataBad = 1'b1;
      end
      if (core_ready) gotCore++;
      if (ldr_ready) gotLdr++;
      if (core_ready || ldr_ready) readyAt = cyc;
    end
    core_req = 1'b0;
    ldr_req  = 1'b0;
    checkOutput("ready_latency", 32'(readyAt), 32'(LAT + 1));
    checkOutput("core_ready_count", 32'(gotCore), 32'(v.expWin == 1'b0));
    checkOutput("ldr_ready_count", 32'(gotLdr), 32'(v.expWin == 1'b1));
    checkOutput("mem_en_cycles", 32'(enCnt), 32'(LAT));
    checkOutput("mem_we_cycles", 32'(weCnt), 32'(expWe));
    if (expWe) checkOutput("mem_we_first_cycle", 32'(weAt), 32'd1);
    checkOutput("mem_addr_latched", 32'(addrBad), 32'd0);
    checkOutput("mem_wdata_latched", 32'(dataBad), 32'd0);
    checkOutput("core_rdata", core_rdata, v.expCoreRd);
    checkOutput("ldr_rdata", ldr_rdata, v.expLdrRd);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_pulse_width", {30'd0, core_ready, ldr_ready}, 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    if (expWe) modelMem[expAddr[7:2]] = expData;
    modelLast   = v.expWin;
    modelCoreRd = v.expCoreRd;
    modelLdrRd  = v.expLdrRd;
  endtask

  initial begin
    int          order [4];
    int          when  [4];
    int          pulses;
    vec_t        rv;
    logic [1:0]  pat;
    bit          sawReady;

    reset = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
    loadMem = 1'b1;
    for (int i = 0; i < 64; i++) modelMem[i] = (i == 2) ? 32'h2002_0005 : 32'hA500_0000 + 32'(i);
    #1 loadMem = 1'b0;

    //            cReq lReq cWe lWe cAddr        lAddr        cData         lData         win expCoreRd     expLdrRd
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h00, 32'h0,        32'h0,        1'b0, 32'h2002_0005, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0C, 32'h0,        32'hAC67_0044, 1'b1, 32'h2002_0005, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0C, 32'h0,        32'h0,        1'b1, 32'h2002_0005, 32'hAC67_0044};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h08, 32'h0,        32'h1111_2222, 1'b0, 32'hAC67_0044, 32'hAC67_0044};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h08, 32'h55,       32'h0,        1'b1, 32'hAC67_0044, 32'h2002_0005};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h00, 32'h55,       32'h0,        1'b0, 32'hAC67_0044, 32'h2002_0005};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h04, 32'h0,        32'h0,        1'b1, 32'hAC67_0044, 32'hA500_0001};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h00, 32'h0,        32'h0,        1'b0, 32'h55,        32'hA500_0001};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h10, 32'h0,        32'h0,        1'b1, 32'h55,        32'h55};

    $display("[TB] reset and idle behaviour");
    doReset();
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_core_rdata", core_rdata, 32'd0);
    checkOutput("reset_ldr_rdata", ldr_rdata, 32'd0);
    checkOutput("reset_readys", {30'd0, core_ready, ldr_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] back-to-back round robin from reset");
    doReset();
    core_we = 1'b0; ldr_we = 1'b0;
    core_addr = 32'h08; ldr_addr = 32'h0C;
    core_req = 1'b1; ldr_req = 1'b1;
    pulses = 0;
    for (int cyc = 1; cyc <= 30 && pulses < 4; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (core_ready && ldr_ready) checkOutput("both_ready", 32'd1, 32'd0);
      if (core_ready || ldr_ready) begin
        order[pulses] = ldr_ready ? 1 : 0;
        when[pulses]  = cyc;
        pulses++;
      end
    end
    core_req = 1'b0; ldr_req = 1'b0;
    checkOutput("rr_pulse_count", 32'(pulses), 32'd4);
    if (pulses == 4) begin
      checkOutput("rr_first_latency", 32'(when[0]), 32'(LAT + 1));
      for (int k = 0; k < 4; k++) checkOutput("rr_order", 32'(order[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) checkOutput("rr_spacing", 32'(when[k] - when[k-1]), 32'(LAT + 2));
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("rr_core_rdata", core_rdata, 32'h2002_0005);
    checkOutput("rr_ldr_rdata", ldr_rdata, 32'hAC67_0044);
    checkOutput("rr_busy_after", 32'(busy), 32'd0);
    modelLast = 1'b1; modelCoreRd = 32'h2002_0005; modelLdrRd = 32'hAC67_0044;

    $display("[TB] address change during access");
    core_we = 1'b0; core_addr = 32'h10; core_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("addrchg_first_access", mem_addr, 32'h10);
    core_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    checkOutput("addrchg_second_access", mem_addr, 32'h10);
    @(posedge clk);
    @(negedge clk);
    checkOutput("addrchg_ready", 32'(core_ready), 32'd1);
    checkOutput("addrchg_rdata", core_rdata, 32'h55);
    core_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    modelLast = 1'b0; modelCoreRd = 32'h55;

    $display("[TB] reset during a write access");
    core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'hDEAD_BEEF; core_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_pre_en", 32'(mem_en), 32'd1);
    checkOutput("abort_pre_we", 32'(mem_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_async_en", 32'(mem_en), 32'd0);
    checkOutput("abort_async_we", 32'(mem_we), 32'd0);
    checkOutput("abort_async_busy", 32'(busy), 32'd0);
    core_req = 1'b0;
    sawReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (core_ready) sawReady = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (core_ready) sawReady = 1'b1;
    end
    checkOutput("abort_no_ready", 32'(sawReady), 32'd0);
    modelLast = 1'b1; modelCoreRd = '0; modelLdrRd = '0;
    applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2002_0005, 32'h0});

    $display("[TB] randomized transactions");
    for (int i = 0; i < 40; i++) begin
      pat      = 2'($urandom_range(1, 3));
      rv.cReq  = pat[0];
      rv.lReq  = pat[1];
      rv.cWe   = 1'($urandom_range(0, 1));
      rv.lWe   = 1'($urandom_range(0, 1));
      rv.cAddr = 32'($urandom_range(0, 15)) << 2;
      rv.lAddr = 32'($urandom_range(0, 15)) << 2;
      rv.cData = $urandom;
      rv.lData = $urandom;
      rv.expWin    = (rv.cReq && rv.lReq) ? !modelLast : rv.lReq;
      rv.expCoreRd = modelCoreRd;
      rv.expLdrRd  = modelLdrRd;
      if (rv.expWin && !rv.lWe)  rv.expLdrRd  = modelMem[rv.lAddr[7:2]];
      if (!rv.expWin && !rv.cWe) rv.expCoreRd = modelMem[rv.cAddr[7:2]];
      applyStimulus(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
